// File: rtl/axi_led_master_if.sv
// AXI4-Lite bus between the LED master and the interconnect.
// Only the channels the LED master actually uses are carried.
interface axi_led_master_if #(
  parameter int unsigned AW = 32
);
  logic [AW-1:0] M_AXI_AWADDR;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY;
  logic [2:0]    M_AXI_AWPROT;
  logic [31:0]   M_AXI_WDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_BVALID;
  logic          M_AXI_BREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [2:0]    M_AXI_ARPROT;
  logic [31:0]   M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_led_master.sv
// AXI4-Lite master that mirrors the board switches into the LED register
// whenever they change, then reads the register back and checks it.
module axi_led_master #(
  parameter int unsigned   AW          = 32,
  parameter logic [AW-1:0] LED_ADDR    = '0,
  parameter int unsigned   SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] switches,
  output logic        busy,
  output logic        resp_err,
  output logic        mismatch,
  output logic [31:0] write_count,
  axi_led_master_if.master m_axi
);
  localparam int unsigned SW_W = 16;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, CHECK} state_t;

  state_t          state_q, state_d;
  logic [SW_W-1:0] sync_q [SYNC_STAGES];
  logic [SW_W-1:0] sw_sync;
  logic [SW_W-1:0] cap_q, cap_d, rb_q, rb_d, last_q, last_d;
  logic            pending_q, pending_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rd_ok_q, rd_ok_d;
  logic            resp_err_d, mismatch_d, busy_d;
  logic [31:0]     write_count_d;
  logic            unused_rdata_hi;

  // Synchronizer is left out of reset so a held switch value survives it
  always_ff @(posedge clk) begin
    sync_q[0] <= switches;
    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
  end
  assign sw_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      rb_q        <= '0;
      last_q      <= '0;
      pending_q   <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rd_ok_q     <= 1'b0;
      resp_err    <= 1'b0;
      mismatch    <= 1'b0;
      busy        <= 1'b0;
      write_count <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      rb_q        <= rb_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rd_ok_q     <= rd_ok_d;
      resp_err    <= resp_err_d;
      mismatch    <= mismatch_d;
      busy        <= busy_d;
      write_count <= write_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cap_d         = cap_q;
    rb_d          = rb_q;
    last_d        = last_q;
    pending_d     = pending_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rd_ok_d       = rd_ok_q;
    resp_err_d    = resp_err;
    mismatch_d    = mismatch;
    write_count_d = write_count;

    unique case (state_q)
      IDLE: begin
        if (pending_q || (sw_sync != last_q)) begin
          cap_d     = sw_sync;
          last_d    = sw_sync;
          pending_d = 1'b0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WRITE;
        end
      end
      // AW and W complete independently; B is only opened after both
      WRITE: begin
        if (awvalid_q && m_axi.M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi.M_AXI_WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (m_axi.M_AXI_BRESP == RESP_OKAY) begin
            write_count_d = write_count + 32'd1;
            arvalid_d     = 1'b1;
            state_d       = READ;
          end else begin
            resp_err_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      READ: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RRESP;
        end
      end
      RRESP: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (m_axi.M_AXI_RRESP != RESP_OKAY) begin
            resp_err_d = 1'b1;
            rd_ok_d    = 1'b0;
          end else begin
            rb_d    = m_axi.M_AXI_RDATA[SW_W-1:0];
            rd_ok_d = 1'b1;
          end
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rd_ok_q && (rb_q != cap_q)) mismatch_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign m_axi.M_AXI_AWADDR  = LED_ADDR;
  assign m_axi.M_AXI_ARADDR  = LED_ADDR;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WDATA   = {16'h0000, cap_q};
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

  // Upper half of the LED register readback carries nothing
  assign unused_rdata_hi = ^m_axi.M_AXI_RDATA[31:16];
endmodule
